mem_access_unit: RTL and testbench
==================================

MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter D_WIDTH, 32, data/address width.
REQ-002 Parameter TIMEOUT, 16, cycles allowed in WAIT before abort (used only under MEM_TIMEOUT_EN).
REQ-003 Clock clk, input, 1, all state updates on rising edge.
REQ-004 Reset rst_n, input, 1, asynchronous, active-low.
REQ-005 i_valid input 1, execute-stage result present; i_MemWriteM input 1, store; i_MemtoRegM input 1, load.
REQ-006 i_RegWriteM input 1, i_PCSrcM input 1, i_WA3M input 4: control forwarded toward the MEM/WB register.
REQ-007 i_ALUResultM input D_WIDTH, address or ALU result; i_WriteDataM input D_WIDTH, store data.
REQ-008 o_mem_req output 1, o_mem_we output 1, o_mem_addr output D_WIDTH, o_mem_wdata output D_WIDTH: data-memory request port.
REQ-009 i_mem_ack input 1, access complete; i_mem_rdata input D_WIDTH, load data, valid with i_mem_ack.
REQ-010 o_RD, o_ALUResultM outputs D_WIDTH; o_RegWriteM, o_PCSrcM, o_MemtoRegM outputs 1; o_WA3M output 4: feed the MEM/WB register.
REQ-011 o_stall output 1, upstream stages hold while high; o_mem_err output 1, sticky timeout flag.

Function
REQ-012 FSM states IDLE, WAIT, DONE; memop = i_valid & (i_MemWriteM | i_MemtoRegM).
REQ-013 IDLE, !memop: outputs combinationally pass inputs (o_RegWriteM/o_PCSrcM gated by i_valid), o_RD = 0, o_stall = 0, stay IDLE.
REQ-014 IDLE, memop: latch address, wdata, we (= i_MemWriteM, store has priority if both set), WA3, RegWrite, PCSrc, MemtoReg; o_stall = 1; next WAIT.
REQ-015 While o_stall = 1, o_RegWriteM, o_PCSrcM, o_MemtoRegM SHALL be 0 (bubble into MEM/WB).
REQ-016 WAIT: o_mem_req = 1 with o_mem_we/addr/wdata driven from latched values, stable until ack; o_stall = 1.
REQ-017 WAIT, i_mem_ack = 1: latch i_mem_rdata into held load data if load, else held load data = 0; next DONE; o_mem_req drops next cycle.
REQ-018 DONE: outputs present latched controls, latched address on o_ALUResultM, held load data on o_RD; o_stall = 0; next IDLE.
REQ-019 o_mem_req SHALL be 0 outside WAIT; i_mem_ack outside WAIT ignored.
REQ-020 Minimum memory-op latency: 3 cycles (IDLE accept, WAIT with ack, DONE); each extra non-ack WAIT cycle adds 1.
REQ-021 Back-to-back memops: a memop presented in the cycle after DONE is accepted normally from IDLE.

Reset
REQ-022 rst_n low asynchronously forces IDLE, all latched registers 0, o_mem_req 0, o_mem_err 0.
REQ-023 Reset during WAIT abandons the access with no completion output.
REQ-024 Out of reset, with i_valid = 0, all outputs are 0.

Configuration
REQ-025 Macro MEM_TIMEOUT_EN defined: WAIT counter counts from 0; on reaching TIMEOUT without ack, set o_mem_err, force held load data to 0, next DONE; ack and timeout in same cycle treated as ack.
REQ-026 MEM_TIMEOUT_EN undefined: no counter, WAIT persists indefinitely, o_mem_err tied 0.
REQ-027 o_mem_err clears only on reset.

Verification
REQ-028 ALU op: i_valid=1, RegWrite=1, ALUResult=0x1234, WA3=5, no memop -> same-cycle o_ALUResultM=0x1234, o_WA3M=5, o_RegWriteM=1, o_stall=0.
REQ-029 Load addr 0x40, ack 1 cycle into WAIT with rdata 0xCAFEF00D -> o_mem_req 1 cycle, DONE o_RD=0xCAFEF00D, o_MemtoRegM=1, o_stall high 2 cycles.
REQ-030 Store addr 0x80 data 0x55, ack after 4 WAIT cycles -> o_mem_we=1, addr/wdata stable all 4 cycles, RegWrite bubbles 0, DONE o_RD=0.
REQ-031 rst_n pulse low in WAIT -> o_mem_req 0 immediately, IDLE, later ack ignored, no completion.
REQ-032 MEM_TIMEOUT_EN, TIMEOUT=16, no ack -> after 16 WAIT cycles o_mem_err=1, DONE o_RD=0, then IDLE; err stays 1.
REQ-033 Two loads back-to-back with immediate acks -> each completes with own rdata, no lost or duplicated DONE.

Source files
------------

// File: rtl/mem_access_unit.sv
// Memory-stage access unit: issues data-memory requests, stalls upstream until ack, feeds MEM/WB.
// Optional WAIT timeout with sticky error flag is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit #(
  parameter int D_WIDTH = 32,
  parameter int TIMEOUT = 16
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               i_valid,
  input  logic               i_MemWriteM,
  input  logic               i_MemtoRegM,
  input  logic               i_RegWriteM,
  input  logic               i_PCSrcM,
  input  logic [3:0]         i_WA3M,
  input  logic [D_WIDTH-1:0] i_ALUResultM,
  input  logic [D_WIDTH-1:0] i_WriteDataM,
  output logic               o_mem_req,
  output logic               o_mem_we,
  output logic [D_WIDTH-1:0] o_mem_addr,
  output logic [D_WIDTH-1:0] o_mem_wdata,
  input  logic               i_mem_ack,
  input  logic [D_WIDTH-1:0] i_mem_rdata,
  output logic [D_WIDTH-1:0] o_RD,
  output logic [D_WIDTH-1:0] o_ALUResultM,
  output logic               o_RegWriteM,
  output logic               o_PCSrcM,
  output logic               o_MemtoRegM,
  output logic [3:0]         o_WA3M,
  output logic               o_stall,
  output logic               o_mem_err
);

  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("mem_access_unit: TIMEOUT must be at least 1");
  end

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t               state_q, state_nxt;
  logic [D_WIDTH-1:0]   addr_q, wdata_q, rd_q;
  logic                 we_q, regwrite_q, pcsrc_q, memtoreg_q, err_q;
  logic [3:0]           wa3_q;
  logic                 memop, timeout_hit;

  assign memop = i_valid & (i_MemWriteM | i_MemtoRegM);

`ifdef MEM_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  logic [CW-1:0] cnt_q;

  assign timeout_hit = (cnt_q == CW'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (state_q == S_WAIT) begin
      cnt_q <= cnt_q + 1'b1;
    end else begin
      cnt_q <= '0;
    end
  end
`else
  assign timeout_hit = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      rd_q       <= '0;
      we_q       <= 1'b0;
      regwrite_q <= 1'b0;
      pcsrc_q    <= 1'b0;
      memtoreg_q <= 1'b0;
      wa3_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_nxt;
      case (state_q)
        S_IDLE: begin
          if (memop) begin
            addr_q     <= i_ALUResultM;
            wdata_q    <= i_WriteDataM;
            we_q       <= i_MemWriteM;
            regwrite_q <= i_RegWriteM;
            pcsrc_q    <= i_PCSrcM;
            memtoreg_q <= i_MemtoRegM;
            wa3_q      <= i_WA3M;
          end
        end
        S_WAIT: begin
          // ack wins over a timeout landing in the same cycle
          if (i_mem_ack) begin
            rd_q <= (memtoreg_q && !we_q) ? i_mem_rdata : '0;
          end else if (timeout_hit) begin
            rd_q  <= '0;
            err_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt    = state_q;
    o_mem_req    = 1'b0;
    o_mem_we     = 1'b0;
    o_mem_addr   = addr_q;
    o_mem_wdata  = wdata_q;
    o_RD         = '0;
    o_ALUResultM = i_ALUResultM;
    o_WA3M       = i_WA3M;
    o_RegWriteM  = 1'b0;
    o_PCSrcM     = 1'b0;
    o_MemtoRegM  = 1'b0;
    o_stall      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (memop) begin
          o_stall   = 1'b1;
          state_nxt = S_WAIT;
        end else begin
          o_RegWriteM = i_valid & i_RegWriteM;
          o_PCSrcM    = i_valid & i_PCSrcM;
          o_MemtoRegM = i_valid & i_MemtoRegM;
        end
      end
      S_WAIT: begin
        o_mem_req    = 1'b1;
        o_mem_we     = we_q;
        o_stall      = 1'b1;
        o_ALUResultM = addr_q;
        o_WA3M       = wa3_q;
        if (i_mem_ack || timeout_hit) begin
          state_nxt = S_DONE;
        end
      end
      S_DONE: begin
        o_RD         = rd_q;
        o_ALUResultM = addr_q;
        o_WA3M       = wa3_q;
        o_RegWriteM  = regwrite_q;
        o_PCSrcM     = pcsrc_q;
        o_MemtoRegM  = memtoreg_q;
        state_nxt    = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  assign o_mem_err = err_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed bench for mem_access_unit: ALU pass-through, load, slow store, reset abort, back-to-back, timeout.
module tb_mem_access_unit;
  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_valid, i_MemWriteM, i_MemtoRegM, i_RegWriteM, i_PCSrcM;
  logic [3:0]  i_WA3M;
  logic [31:0] i_ALUResultM, i_WriteDataM;
  logic        o_mem_req, o_mem_we;
  logic [31:0] o_mem_addr, o_mem_wdata;
  logic        i_mem_ack;
  logic [31:0] i_mem_rdata;
  logic [31:0] o_RD, o_ALUResultM;
  logic        o_RegWriteM, o_PCSrcM, o_MemtoRegM;
  logic [3:0]  o_WA3M;
  logic        o_stall, o_mem_err;

  int n_tests = 0;
  int n_fail  = 0;

  mem_access_unit #(.D_WIDTH(32), .TIMEOUT(16)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_valid(i_valid), .i_MemWriteM(i_MemWriteM), .i_MemtoRegM(i_MemtoRegM),
    .i_RegWriteM(i_RegWriteM), .i_PCSrcM(i_PCSrcM), .i_WA3M(i_WA3M),
    .i_ALUResultM(i_ALUResultM), .i_WriteDataM(i_WriteDataM),
    .o_mem_req(o_mem_req), .o_mem_we(o_mem_we), .o_mem_addr(o_mem_addr),
    .o_mem_wdata(o_mem_wdata), .i_mem_ack(i_mem_ack), .i_mem_rdata(i_mem_rdata),
    .o_RD(o_RD), .o_ALUResultM(o_ALUResultM), .o_RegWriteM(o_RegWriteM),
    .o_PCSrcM(o_PCSrcM), .o_MemtoRegM(o_MemtoRegM), .o_WA3M(o_WA3M),
    .o_stall(o_stall), .o_mem_err(o_mem_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // advance to just after the next rising edge; inputs are then driven and outputs sampled at +2
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic mw, input logic mr, input logic rw,
                       input logic pc, input logic [3:0] wa, input logic [31:0] alu,
                       input logic [31:0] wd);
    i_valid = v; i_MemWriteM = mw; i_MemtoRegM = mr; i_RegWriteM = rw;
    i_PCSrcM = pc; i_WA3M = wa; i_ALUResultM = alu; i_WriteDataM = wd;
    #1;
  endtask

  task automatic idle_inputs();
    i_mem_ack = 1'b0; i_mem_rdata = '0;
    drive(1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 32'd0, 32'd0);
  endtask

  // one load with ack in its first WAIT cycle; checks the DONE view
  task automatic load_imm(input string tag, input logic [31:0] addr, input logic [31:0] data,
                          input logic [3:0] wa);
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, wa, addr, 32'd0);
    check({tag, "_accept_stall"}, {31'd0, o_stall}, 32'd1);
    check({tag, "_accept_rw"}, {31'd0, o_RegWriteM}, 32'd0);
    next_cycle();
    i_mem_ack = 1'b1; i_mem_rdata = data; #1;
    check({tag, "_wait_req"}, {31'd0, o_mem_req}, 32'd1);
    check({tag, "_wait_addr"}, o_mem_addr, addr);
    check({tag, "_wait_stall"}, {31'd0, o_stall}, 32'd1);
    next_cycle();
    i_mem_ack = 1'b0; i_mem_rdata = 32'hBAD0BAD0; #1;
    check({tag, "_done_req"}, {31'd0, o_mem_req}, 32'd0);
    check({tag, "_done_stall"}, {31'd0, o_stall}, 32'd0);
    check({tag, "_done_rd"}, o_RD, data);
    check({tag, "_done_m2r"}, {31'd0, o_MemtoRegM}, 32'd1);
    check({tag, "_done_rw"}, {31'd0, o_RegWriteM}, 32'd1);
    check({tag, "_done_wa3"}, {28'd0, o_WA3M}, {28'd0, wa});
    check({tag, "_done_alu"}, o_ALUResultM, addr);
    next_cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    idle_inputs();
    #12;
    check("rst_req", {31'd0, o_mem_req}, 32'd0);
    check("rst_outs", {o_RD | o_ALUResultM | o_mem_addr | o_mem_wdata}, 32'd0);
    check("rst_ctl", {24'd0, o_RegWriteM, o_PCSrcM, o_MemtoRegM, o_stall, o_mem_err,
                      o_mem_we, 2'b00}, 32'd0);
    rst_n = 1'b1;
    next_cycle();

    // ALU op passes through the same cycle
    drive(1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 4'd5, 32'h1234, 32'd0);
    check("alu_res", o_ALUResultM, 32'h1234);
    check("alu_wa3", {28'd0, o_WA3M}, 32'd5);
    check("alu_rw", {31'd0, o_RegWriteM}, 32'd1);
    check("alu_stall", {31'd0, o_stall}, 32'd0);
    check("alu_rd", o_RD, 32'd0);
    // control gated by i_valid; ack outside WAIT ignored
    i_mem_ack = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'd2, 32'h9, 32'd0);
    check("inv_rw", {31'd0, o_RegWriteM}, 32'd0);
    check("inv_pc", {31'd0, o_PCSrcM}, 32'd0);
    check("ack_idle_req", {31'd0, o_mem_req}, 32'd0);
    drive(1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 4'd2, 32'h9, 32'd0);
    check("br_pc", {31'd0, o_PCSrcM}, 32'd1);
    next_cycle();
    check("ack_idle_state", {31'd0, o_stall}, 32'd0);
    idle_inputs();

    load_imm("ld", 32'h40, 32'hCAFEF00D, 4'd3);

    // store with ack on the 4th WAIT cycle
    drive(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 4'd7, 32'h80, 32'h55);
    check("st_accept_stall", {31'd0, o_stall}, 32'd1);
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      i_mem_ack = (i == 3); i_mem_rdata = 32'hDEADBEEF; #1;
      check("st_req", {31'd0, o_mem_req}, 32'd1);
      check("st_we", {31'd0, o_mem_we}, 32'd1);
      check("st_addr", o_mem_addr, 32'h80);
      check("st_wdata", o_mem_wdata, 32'h55);
      check("st_bubble", {29'd0, o_RegWriteM, o_PCSrcM, o_MemtoRegM}, 32'd0);
      check("st_stall", {31'd0, o_stall}, 32'd1);
    end
    next_cycle();
    i_mem_ack = 1'b0; #1;
    check("st_done_rd", o_RD, 32'd0);
    check("st_done_stall", {31'd0, o_stall}, 32'd0);
    check("st_done_req", {31'd0, o_mem_req}, 32'd0);
    next_cycle();
    idle_inputs();

    // reset pulse during WAIT abandons the access
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd9, 32'h200, 32'd0);
    next_cycle();
    check("rw_req_pre", {31'd0, o_mem_req}, 32'd1);
    idle_inputs();
    rst_n = 1'b0; #1;
    check("rw_req_async", {31'd0, o_mem_req}, 32'd0);
    #2 rst_n = 1'b1;
    next_cycle();
    i_mem_ack = 1'b1; i_mem_rdata = 32'h77777777; #1;
    check("rw_ack_req", {31'd0, o_mem_req}, 32'd0);
    next_cycle();
    i_mem_ack = 1'b0; #1;
    check("rw_no_done", {30'd0, o_RegWriteM, o_MemtoRegM}, 32'd0);
    check("rw_no_rd", o_RD, 32'd0);
    check("rw_stall", {31'd0, o_stall}, 32'd0);

    // back-to-back loads
    load_imm("b2b0", 32'h100, 32'h11111111, 4'd1);
    load_imm("b2b1", 32'h104, 32'h22222222, 4'd2);
    idle_inputs();
    check("b2b_after_rw", {31'd0, o_RegWriteM}, 32'd0);

    // no ack for 16 WAIT cycles
    drive(1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 4'd4, 32'h300, 32'd0);
    for (int i = 0; i < 16; i++) begin
      next_cycle();
      check("to_wait_req", {31'd0, o_mem_req}, 32'd1);
      check("to_wait_err", {31'd0, o_mem_err}, 32'd0);
    end
    next_cycle();
`ifdef MEM_TIMEOUT_EN
    check("to_done_err", {31'd0, o_mem_err}, 32'd1);
    check("to_done_req", {31'd0, o_mem_req}, 32'd0);
    check("to_done_rd", o_RD, 32'd0);
    check("to_done_stall", {31'd0, o_stall}, 32'd0);
    next_cycle();
    idle_inputs();
    check("to_idle_err", {31'd0, o_mem_err}, 32'd1);
    check("to_idle_rw", {31'd0, o_RegWriteM}, 32'd0);
`else
    check("nto_wait_req", {31'd0, o_mem_req}, 32'd1);
    check("nto_err", {31'd0, o_mem_err}, 32'd0);
    i_mem_ack = 1'b1; i_mem_rdata = 32'hABCD0123; #1;
    next_cycle();
    i_mem_ack = 1'b0; #1;
    check("nto_done_rd", o_RD, 32'hABCD0123);
    check("nto_done_err", {31'd0, o_mem_err}, 32'd0);
    next_cycle();
    idle_inputs();
`endif
    rst_n = 1'b0; #1;
    check("final_rst_err", {31'd0, o_mem_err}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end
endmodule
